// File: rtl/pbus_dma_master_pkg.sv
// rtl/pbus_dma_master_pkg.sv - state encoding, default sizes and peripheral-map bases for the pbus DMA master
package pbus_dma_master_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_LEN_W   = 12;
    localparam int DEF_TMO_CYC = 255;

    // Peripheral-map bases, kept in step with the bus decoder
    localparam logic [11:0] PERIPH_BASE = 12'h000;
    localparam logic [11:0] SPM_BASE    = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/pbus_dma_master_ack_timer.sv
// rtl/pbus_dma_master_ack_timer.sv - per-access ACK wait counter with expiry flag
module pbus_dma_master_ack_timer #(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CW    = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TMO_CYC - 1);

    logic [CW-1:0] r_wait;

    // Expired flags the last allowed wait cycle so the FSM can leave on that edge
    assign o_expired = (r_wait == LIMIT);

    // Count unacknowledged strobe cycles; saturate once the limit is reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (i_clr) begin
            r_wait <= '0;
        end else if (i_en && !o_expired) begin
            r_wait <= r_wait + 1'b1;
        end
    end

endmodule

// File: rtl/pbus_dma_master.sv
// rtl/pbus_dma_master.sv - Wishbone byte-copy DMA initiator for the 4K peripheral bus
module pbus_dma_master
    import pbus_dma_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] WB_ADRo,
    output logic [7:0]        WB_DATo,
    input  logic [7:0]        WB_DATi,
    output logic              WB_WEo,
    output logic              WB_CYCo,
    output logic              WB_STBo,
    input  logic              WB_ACKi
);

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_buf;

    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [7:0]        w_buf_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_cyc_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_adr_nxt;
    logic [ADDR_W-1:0] w_err_addr_nxt;

    logic              w_in_bus;
    logic              w_ack;
    logic              w_last;
    logic              w_expired;

    // ACK only means something while our strobe is up (RD/WR)
    assign w_in_bus = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_ack    = w_in_bus && WB_ACKi;
    assign w_last   = (r_cnt == LEN_W'(1));

    pbus_dma_master_ack_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_ack || !w_in_bus),
        .i_en      (w_in_bus),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: abort dominates, then ACK, then timeout
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = (len == '0) ? ST_FIN : ST_RD;
                ST_RD: begin
                    if (WB_ACKi)        w_state_nxt = ST_WR;
                    else if (w_expired) w_state_nxt = ST_ERR;
                end
                ST_WR: begin
                    if (WB_ACKi)        w_state_nxt = w_last ? ST_FIN : ST_RD;
                    else if (w_expired) w_state_nxt = ST_ERR;
                end
                ST_FIN:  w_state_nxt = ST_IDLE;
                ST_ERR:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath and bus outputs for the coming cycle, derived from the next state
    always_comb begin
        w_src_nxt = r_src;
        w_dst_nxt = r_dst;
        w_cnt_nxt = r_cnt;
        w_buf_nxt = r_buf;
        if (r_state == ST_IDLE && start && !abort) begin
            w_src_nxt = src_addr;
            w_dst_nxt = dst_addr;
            w_cnt_nxt = len;
        end
        if (r_state == ST_RD && WB_ACKi) begin
            w_buf_nxt = WB_DATi;
        end
        if (r_state == ST_WR && WB_ACKi) begin
            w_src_nxt = r_src + 1'b1;
            w_dst_nxt = r_dst + 1'b1;
            w_cnt_nxt = r_cnt - 1'b1;
        end
        w_cyc_nxt      = (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
        w_we_nxt       = (w_state_nxt == ST_WR);
        w_busy_nxt     = w_cyc_nxt || (w_state_nxt == ST_FIN);
        w_done_nxt     = (w_state_nxt == ST_FIN);
        w_err_nxt      = (w_state_nxt == ST_ERR);
        w_adr_nxt      = w_we_nxt ? w_dst_nxt : w_src_nxt;
        w_err_addr_nxt = w_err_nxt ? WB_ADRo : err_addr;
    end

    // Register datapath and every output so no ACK-to-STB path exists
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_cnt    <= '0;
            r_buf    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            WB_ADRo  <= '0;
            WB_DATo  <= '0;
            WB_WEo   <= 1'b0;
            WB_CYCo  <= 1'b0;
            WB_STBo  <= 1'b0;
        end else begin
            r_src    <= w_src_nxt;
            r_dst    <= w_dst_nxt;
            r_cnt    <= w_cnt_nxt;
            r_buf    <= w_buf_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            err      <= w_err_nxt;
            err_addr <= w_err_addr_nxt;
            WB_ADRo  <= w_adr_nxt;
            WB_DATo  <= w_buf_nxt;
            WB_WEo   <= w_we_nxt;
            WB_CYCo  <= w_cyc_nxt;
            WB_STBo  <= w_cyc_nxt;
        end
    end

endmodule

// File: tb/tb_pbus_dma_master.sv
// tb/tb_pbus_dma_master.sv - self-checking bench for pbus_dma_master
module tb_pbus_dma_master;
    import pbus_dma_master_pkg::*;

    localparam int AW  = 12;
    localparam int LW  = 12;
    localparam int TMO = 8;
    localparam logic [11:0] HOLE = PERIPH_BASE + 12'h600;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, err;
    logic [AW-1:0] err_addr, WB_ADRo;
    logic [7:0]    WB_DATo, WB_DATi;
    logic          WB_WEo, WB_CYCo, WB_STBo, WB_ACKi;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    mem     [4096];
    logic [7:0]    ref_mem [4096];
    int            wait_states = 0;
    bit            unmapped_en = 1'b0;
    int            wcnt = 0;
    bit            log_we  [$];
    logic [AW-1:0] log_adr [$];

    always #5 clk = ~clk;

    pbus_dma_master #(
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TMO_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr),
        .WB_ADRo  (WB_ADRo),
        .WB_DATo  (WB_DATo),
        .WB_DATi  (WB_DATi),
        .WB_WEo   (WB_WEo),
        .WB_CYCo  (WB_CYCo),
        .WB_STBo  (WB_STBo),
        .WB_ACKi  (WB_ACKi)
    );

    // Byte-wide memory responder with programmable wait states and an unmapped hole
    assign WB_ACKi = WB_CYCo && WB_STBo && (wcnt >= wait_states)
                     && !(unmapped_en && WB_ADRo[11:8] == HOLE[11:8]);
    assign WB_DATi = mem[WB_ADRo];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 0;
        end else if (WB_CYCo && WB_STBo) begin
            if (WB_ACKi) begin
                wcnt <= 0;
                log_we.push_back(WB_WEo);
                log_adr.push_back(WB_ADRo);
                if (WB_WEo) mem[WB_ADRo] <= WB_DATo;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [11:0] s, input logic [11:0] d, input int n, input int w,
                            output int bc, output int dc, output int ec, output int da,
                            output int ea, output int cs, output bit fin);
        wait_states = w;
        log_we.delete();
        log_adr.delete();
        @(negedge clk);
        src_addr = s; dst_addr = d; len = LW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0; dc = 0; ec = 0; da = -1; ea = -1; cs = 0; fin = 1'b0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            if (busy)    bc++;
            if (done)    begin dc++; da = k; end
            if (err)     begin ec++; ea = k; end
            if (WB_CYCo) cs++;
            if (!busy) fin = 1'b1;
            else       @(negedge clk);
        end
    endtask

    task automatic copy_test(input logic [11:0] s, input logic [11:0] d, input int n,
                             input int w, input string tag);
        int bc, dc, ec, da, ea, cs, bad, exp_busy;
        bit fin;
        logic [11:0] ra, wa;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < n; i++) begin
            ra = s + 12'(i);
            wa = d + 12'(i);
            ref_mem[wa] = ref_mem[ra];
        end
        run_xfer(s, d, n, w, bc, dc, ec, da, ea, cs, fin);
        exp_busy = 2 * n * (w + 1) + 1;
        check_eq({tag, " finished"},    32'(fin), 1);
        check_eq({tag, " busy_cycles"}, bc, exp_busy);
        check_eq({tag, " done_count"},  dc, 1);
        check_eq({tag, " done_at"},     da, exp_busy - 1);
        check_eq({tag, " err_count"},   ec, 0);
        check_eq({tag, " cyc_cycles"},  cs, exp_busy - 1);
        check_eq({tag, " accesses"},    log_we.size(), 2 * n);
        bad = 0;
        for (int i = 0; i < log_we.size(); i++) begin
            wa = ((i % 2) == 1) ? d + 12'(i / 2) : s + 12'(i / 2);
            if (log_we[i] != ((i % 2) == 1) || log_adr[i] !== wa) bad++;
        end
        check_eq({tag, " access_seq"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq({tag, " mem"}, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        int bc, dc, ec, da, ea, cs, pulses;
        bit fin, found;
        logic [7:0] b0;
        logic [11:0] s, d;
        int n, w;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check_eq("reset busy",    busy, 0);
        check_eq("reset done",    done, 0);
        check_eq("reset err",     err, 0);
        check_eq("reset err_addr", err_addr, 0);
        check_eq("reset bus",     {WB_CYCo, WB_STBo, WB_WEo}, 0);
        check_eq("reset adr",     WB_ADRo, 0);
        check_eq("reset dat",     WB_DATo, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        copy_test(SPM_BASE, SPM_BASE + 12'h100, 4, 0, "copy4");
        copy_test(SPM_BASE + 12'h10, SPM_BASE + 12'h20, 0, 0, "len0");
        copy_test(SPM_BASE + 12'h30, SPM_BASE + 12'h200, 2, 3, "wait3");

        // ACK timeout on an unmapped source
        unmapped_en = 1'b1;
        run_xfer(PERIPH_BASE + 12'h650, SPM_BASE, 1, 0, bc, dc, ec, da, ea, cs, fin);
        unmapped_en = 1'b0;
        check_eq("tmo finished",  32'(fin), 1);
        check_eq("tmo err_count", ec, 1);
        check_eq("tmo err_at",    ea, TMO);
        check_eq("tmo done",      dc, 0);
        check_eq("tmo err_addr",  err_addr, PERIPH_BASE + 12'h650);
        check_eq("tmo cyc",       WB_CYCo, 0);
        copy_test(SPM_BASE + 12'h300, SPM_BASE + 12'h340, 3, 1, "after_tmo");

        // Wrapping copy aborted in the second write; a start while busy is ignored
        wait_states = 1;
        log_we.delete();
        log_adr.delete();
        b0 = mem[12'hFFF];
        @(negedge clk);
        src_addr = 12'hFFF; dst_addr = 12'h7FE; len = 12'd3; start = 1'b1;
        @(negedge clk);
        src_addr = 12'h123; dst_addr = 12'h456; len = 12'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (WB_CYCo && WB_WEo && log_adr.size() == 3) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("abort reached_wr2", 32'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort bus", {WB_CYCo, WB_STBo, WB_WEo}, 0);
        check_eq("abort busy", busy, 0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || err || busy || WB_CYCo) pulses++;
        end
        check_eq("abort quiet",    pulses, 0);
        check_eq("abort accesses", log_adr.size(), 3);
        check_eq("abort rd0",      log_adr[0], 12'hFFF);
        check_eq("abort wr0",      log_adr[1], 12'h7FE);
        check_eq("abort rd1_wrap", log_adr[2], 12'h000);
        check_eq("abort wr0_data", mem[12'h7FE], b0);

        // Asynchronous reset in the middle of a read
        wait_states = 5;
        @(negedge clk);
        src_addr = SPM_BASE; dst_addr = SPM_BASE + 12'h40; len = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("rst pre_cyc", WB_CYCo, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst cyc_now", WB_CYCo, 0);
        check_eq("rst stb_now", WB_STBo, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || err || busy || WB_CYCo) pulses++;
        end
        check_eq("rst quiet", pulses, 0);

        for (int t = 0; t < 30; t++) begin
            s = 12'($urandom);
            d = 12'($urandom);
            n = $urandom_range(1, 24);
            w = $urandom_range(0, 3);
            if (t % 5 == 0) s = 12'hFFF - 12'($urandom_range(0, 3));
            copy_test(s, d, n, w, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
